// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: turns bit-reversed final-stage FFT output into natural order.
// Define FFT_REORDER_LAST_EN to add the out_last end-of-frame marker.
module fft_reorder_buffer #(
   parameter int NBITS = 16,
   parameter int LOG2N = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [NBITS-1:0] in_re,
   input  logic signed [NBITS-1:0] in_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [NBITS-1:0] out_re,
   output logic signed [NBITS-1:0] out_im
`ifdef FFT_REORDER_LAST_EN
   ,
   output logic                    out_last
`endif
);

   localparam int N = 1 << LOG2N;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   // Both banks live in one array; the MSB of the address selects the bank.
   logic signed [NBITS-1:0] mem_re [0:2*N-1];
   logic signed [NBITS-1:0] mem_im [0:2*N-1];

   logic [1:0]       bank_full;
   logic [1:0]       bank_full_nxt;
   logic             wbank;
   logic             rbank;
   logic [LOG2N-1:0] wcnt;
   logic [LOG2N-1:0] rcnt;
   logic             wr_en;
   logic             rd_en;
   logic             wr_last;
   logic             rd_last;
   logic [LOG2N:0]   wr_addr;
   logic [LOG2N:0]   rd_addr;

   assign in_ready  = ~bank_full[wbank];
   assign out_valid = bank_full[rbank];
   assign wr_en     = in_valid & in_ready;
   assign rd_en     = out_valid & out_ready;
   assign wr_last   = wr_en & (wcnt == '1);
   assign rd_last   = rd_en & (rcnt == '1);
   assign wr_addr   = {wbank, bitrev(wcnt)};
   assign rd_addr   = {rbank, rcnt};

   // The filling bank is EMPTY and the draining bank is FULL, so both updates never collide.
   always_comb begin
      bank_full_nxt = bank_full;
      if (wr_last) bank_full_nxt[wbank] = 1'b1;
      if (rd_last) bank_full_nxt[rbank] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full <= 2'b00;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
      end else begin
         bank_full <= bank_full_nxt;
         if (wr_en) begin
            wcnt <= wcnt + 1'b1;
            if (wr_last) wbank <= ~wbank;
         end
         if (rd_en) begin
            rcnt <= rcnt + 1'b1;
            if (rd_last) rbank <= ~rbank;
         end
      end
   end

   // Sample storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_addr] <= in_re;
         mem_im[wr_addr] <= in_im;
      end
   end

   assign out_re = out_valid ? mem_re[rd_addr] : '0;
   assign out_im = out_valid ? mem_im[rd_addr] : '0;

`ifdef FFT_REORDER_LAST_EN
   assign out_last = out_valid & (rcnt == '1);
`endif

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed self-checking bench for fft_reorder_buffer (N = 16).
module tb_fft_reorder_buffer;

   localparam int NBITS = 16;
   localparam int LOG2N = 4;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [NBITS-1:0] in_re;
   logic signed [NBITS-1:0] in_im;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [NBITS-1:0] out_re;
   logic signed [NBITS-1:0] out_im;
`ifdef FFT_REORDER_LAST_EN
   logic                    out_last;
`endif

   int nvec = 0;
   int nerr = 0;
   // Natural-order position n holds the input sample with index bitrev(n).
   int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fft_reorder_buffer #(.NBITS(NBITS), .LOG2N(LOG2N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im)
`ifdef FFT_REORDER_LAST_EN
      ,
      .out_last  (out_last)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int re, input int im, input logic ordy);
      in_valid  = v;
      in_re     = NBITS'(re);
      in_im     = NBITS'(im);
      out_ready = ordy;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      logic ordy;
      drive(1'b0, 0, 0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
`ifdef FFT_REORDER_LAST_EN
      chk("rst_out_last", out_last, 0);
`endif
      #10;
      rst_n = 1'b1;
      next_cycle();

      // Single frame 0..15, outputs in bit-reversed index order
      for (int c = 0; c < 32; c++) begin
         if (c < 16) drive(1'b1, c, 0, 1'b1);
         else        drive(1'b0, 0, 0, 1'b1);
         @(negedge clk);
         if (c < 16) begin
            chk("t1_in_ready", in_ready, 1);
            chk("t1_no_early_valid", out_valid, 0);
         end else begin
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_re", out_re, br[c-16]);
            chk("t1_out_im", out_im, 0);
`ifdef FFT_REORDER_LAST_EN
            chk("t1_out_last", out_last, (c == 31) ? 1 : 0);
`endif
         end
         next_cycle();
      end
      @(negedge clk);
      chk("t1_drained_valid", out_valid, 0);
      chk("t1_drained_re", out_re, 0);
      next_cycle();

      // Three back-to-back frames, full throughput
      for (int c = 0; c < 64; c++) begin
         if (c < 48) drive(1'b1, 200 + c, -(200 + c), 1'b1);
         else        drive(1'b0, 0, 0, 1'b1);
         @(negedge clk);
         if (c < 48) chk("t2_in_ready", in_ready, 1);
         if (c >= 16) begin
            chk("t2_out_valid", out_valid, 1);
            chk("t2_out_re", out_re, 200 + ((c - 16) / 16) * 16 + br[(c - 16) % 16]);
            chk("t2_out_im", out_im, -(200 + ((c - 16) / 16) * 16 + br[(c - 16) % 16]));
`ifdef FFT_REORDER_LAST_EN
            chk("t2_out_last", out_last, ((c - 16) % 16 == 15) ? 1 : 0);
`endif
         end else begin
            chk("t2_no_early_valid", out_valid, 0);
         end
         next_cycle();
      end
      @(negedge clk);
      chk("t2_drained_valid", out_valid, 0);
      next_cycle();

      // Two frames with downstream stalled, then a refused write, then drain
      for (int c = 0; c < 32; c++) begin
         drive(1'b1, 300 + c, 7, 1'b0);
         @(negedge clk);
         chk("t3_in_ready_fill", in_ready, 1);
         if (c >= 16) begin
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_re", out_re, 300);
         end
         next_cycle();
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 999, 999, 1'b0);
         @(negedge clk);
         chk("t3_in_ready_full", in_ready, 0);
         chk("t3_full_valid", out_valid, 1);
         chk("t3_full_re", out_re, 300);
         next_cycle();
      end
      for (int c = 0; c < 32; c++) begin
         drive(1'b0, 0, 0, 1'b1);
         @(negedge clk);
         chk("t3_drain_valid", out_valid, 1);
         chk("t3_drain_re", out_re, 300 + (c / 16) * 16 + br[c % 16]);
         chk("t3_drain_im", out_im, 7);
         next_cycle();
      end
      @(negedge clk);
      chk("t3_drained_valid", out_valid, 0);
      chk("t3_drained_ready", in_ready, 1);
      next_cycle();

      // Drain with out_ready toggling every cycle
      for (int c = 0; c < 16; c++) begin
         drive(1'b1, 400 + c, -1, 1'b0);
         next_cycle();
      end
      idx = 0;
      for (int t = 0; t < 40 && idx < 16; t++) begin
         ordy = ((t % 2) == 0);
         drive(1'b0, 0, 0, ordy);
         @(negedge clk);
         chk("t4_out_valid", out_valid, 1);
         chk("t4_out_re", out_re, 400 + br[idx]);
         chk("t4_out_im", out_im, -1);
`ifdef FFT_REORDER_LAST_EN
         chk("t4_out_last", out_last, (idx == 15) ? 1 : 0);
`endif
         next_cycle();
         if (ordy) idx++;
      end
      chk("t4_all_delivered", idx, 16);
      drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("t4_drained_valid", out_valid, 0);
      next_cycle();

      // Reset in mid-frame discards the partial frame
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, 50 + c, 50 + c, 1'b1);
         next_cycle();
      end
      drive(1'b0, 0, 0, 1'b1);
      rst_n = 1'b0;
      #2;
      chk("t5_rst_in_ready", in_ready, 1);
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_out_re", out_re, 0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      for (int c = 0; c < 32; c++) begin
         if (c < 16) drive(1'b1, 100 + c, 0, 1'b1);
         else        drive(1'b0, 0, 0, 1'b1);
         @(negedge clk);
         if (c < 16) begin
            chk("t5_no_early_valid", out_valid, 0);
         end else begin
            chk("t5_out_valid", out_valid, 1);
            chk("t5_out_re", out_re, 100 + br[c-16]);
         end
         next_cycle();
      end
      @(negedge clk);
      chk("t5_drained_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
